// File: rtl/hazard_scoreboard_if.sv
// Decode/pipeline-side bundle for the pending-write hazard scoreboard.
// The master modport belongs to the decode/pipeline side. The slave modport
// belongs to the scoreboard.
interface hazard_scoreboard_if #(
    parameter int NREGS  = 32,
    parameter int PERF_W = 32
);
    localparam int IDX_W = $clog2(NREGS);

    logic [IDX_W-1:0]  i_rs1;
    logic [IDX_W-1:0]  i_rs2;
    logic [1:0]        i_check_regs;
    logic              i_id_valid;
    logic              i_id_wr;
    logic [IDX_W-1:0]  i_id_rd;
    logic              i_hold;
    logic              i_wb_valid;
    logic [IDX_W-1:0]  i_wb_rd;
    logic              i_flush;
    logic              i_pipe_empty;

    logic              o_stall;
    logic              o_stall_rs1;
    logic              o_stall_rs2;
    logic [NREGS-1:0]  o_busy_vec;
    logic              o_draining;
    logic [PERF_W-1:0] o_stall_cnt;
    logic              o_overflow;

    modport master (
        output i_rs1, i_rs2, i_check_regs, i_id_valid, i_id_wr, i_id_rd,
               i_hold, i_wb_valid, i_wb_rd, i_flush, i_pipe_empty,
        input  o_stall, o_stall_rs1, o_stall_rs2, o_busy_vec, o_draining,
               o_stall_cnt, o_overflow
    );

    modport slave (
        input  i_rs1, i_rs2, i_check_regs, i_id_valid, i_id_wr, i_id_rd,
               i_hold, i_wb_valid, i_wb_rd, i_flush, i_pipe_empty,
        output o_stall, o_stall_rs1, o_stall_rs2, o_busy_vec, o_draining,
               o_stall_cnt, o_overflow
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard between decode and EXE.
// It counts in-flight writes per register and stalls ID on RAW hazards or on
// pending-counter saturation. On a flush it drains the pipeline and then
// clears all pending counts. It also keeps a saturating stall-cycle counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal issue; hazards checked against pending counts
// ST_DRAIN | flush seen; ID stalled until the pipeline reports empty
module hazard_scoreboard #(
    parameter int NREGS  = 32,
    parameter int PEND_W = 2,
    parameter int PERF_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    hazard_scoreboard_if.slave   bus
);
    localparam int IDX_W = $clog2(NREGS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PERF_W-1:0] CNT_MAX  = '1;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t            state;
    logic [PEND_W-1:0] pend [NREGS];
    logic [PERF_W-1:0] stall_cnt;
    logic              overflow;

    logic              in_run;
    logic              wb_hits_rs1;
    logic              wb_hits_rs2;
    logic              hz1;
    logic              hz2;
    logic              sat;
    logic              stall;
    logic              accept;
    logic [NREGS-1:0]  inc;
    logic [NREGS-1:0]  dec;
    logic [NREGS-1:0]  busy;

    // Hazard detection and issue acceptance.
    // A write retiring this cycle is subtracted first, because the regfile is
    // write-through. A retire against a zero count does not wrap into a hazard.
    always_comb begin
        in_run      = (state == ST_RUN);
        wb_hits_rs1 = bus.i_wb_valid && (bus.i_wb_rd == bus.i_rs1);
        wb_hits_rs2 = bus.i_wb_valid && (bus.i_wb_rd == bus.i_rs2);
        hz1 = bus.i_check_regs[0] && (bus.i_rs1 != '0) &&
              (pend[bus.i_rs1] > PEND_W'(wb_hits_rs1));
        hz2 = bus.i_check_regs[1] && (bus.i_rs2 != '0) &&
              (pend[bus.i_rs2] > PEND_W'(wb_hits_rs2));
        sat = bus.i_id_wr && (bus.i_id_rd != '0) && (pend[bus.i_id_rd] == PEND_MAX);
        stall  = !in_run || (bus.i_id_valid && (hz1 || hz2 || sat));
        accept = in_run && bus.i_id_valid && !stall && !bus.i_hold && !bus.i_flush;
    end

    // Per-register increment/decrement requests and the busy view.
    // Register 0 is never tracked.
    always_comb begin
        inc  = '0;
        dec  = '0;
        busy = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc[r]  = accept && bus.i_id_wr && (bus.i_id_rd == IDX_W'(r));
            dec[r]  = bus.i_wb_valid && (bus.i_wb_rd == IDX_W'(r)) && (pend[r] != '0);
            busy[r] = (pend[r] != '0);
        end
    end

    // FSM, pending counters and the sticky overflow flag.
    // An issue and a retire on the same register in one cycle leave the count unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_RUN;
            overflow <= 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                pend[r] <= '0;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.i_flush) begin
                        state <= ST_DRAIN;
                        if (bus.i_id_valid && sat) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.i_pipe_empty) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
            for (int r = 0; r < NREGS; r++) begin
                if ((state == ST_DRAIN) && bus.i_pipe_empty) begin
                    pend[r] <= '0;
                end else if (inc[r] && !dec[r]) begin
                    pend[r] <= pend[r] + PEND_W'(1);
                end else if (dec[r] && !inc[r]) begin
                    pend[r] <= pend[r] - PEND_W'(1);
                end
            end
        end
    end

    // Saturating count of cycles in which ID is stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    assign bus.o_stall     = stall;
    assign bus.o_stall_rs1 = in_run && hz1;
    assign bus.o_stall_rs2 = in_run && hz2;
    assign bus.o_busy_vec  = busy;
    assign bus.o_draining  = (state == ST_DRAIN);
    assign bus.o_stall_cnt = stall_cnt;
    assign bus.o_overflow  = overflow;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. It uses NREGS=32, PEND_W=2, PERF_W=4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled a further
// 1 time unit later, well away from the next edge.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    hazard_scoreboard_if #(.NREGS(32), .PERF_W(4)) bus ();

    hazard_scoreboard #(.NREGS(32), .PEND_W(2), .PERF_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.i_rs1 = '0;  bus.i_rs2 = '0;  bus.i_check_regs = 2'b00;
        bus.i_id_valid = 1'b0;  bus.i_id_wr = 1'b0;  bus.i_id_rd = '0;
        bus.i_hold = 1'b0;  bus.i_wb_valid = 1'b0;  bus.i_wb_rd = '0;
        bus.i_flush = 1'b0;  bus.i_pipe_empty = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        idle();
        bus.i_id_valid = 1'b1;  bus.i_id_wr = 1'b1;  bus.i_id_rd = rd;
        tick();
    endtask

    task automatic retire(input logic [4:0] rd);
        idle();
        bus.i_wb_valid = 1'b1;  bus.i_wb_rd = rd;
        tick();
    endtask

    initial begin
        // Reset values
        idle();
        #1;
        check("rst_stall",    32'(bus.o_stall), 32'd0);
        check("rst_stall_rs1", 32'(bus.o_stall_rs1), 32'd0);
        check("rst_stall_rs2", 32'(bus.o_stall_rs2), 32'd0);
        check("rst_busy",     bus.o_busy_vec, 32'h0);
        check("rst_drain",    32'(bus.o_draining), 32'd0);
        check("rst_cnt",      32'(bus.o_stall_cnt), 32'd0);
        check("rst_ovf",      32'(bus.o_overflow), 32'd0);
        #2 rst = 1'b0;
        tick();

        // Write x5, then read it: stall until the retire cycle
        issue_wr(5'd5);
        check("t1_busy5", bus.o_busy_vec, 32'h0000_0020);
        idle();
        bus.i_id_valid = 1'b1;  bus.i_rs1 = 5'd5;  bus.i_check_regs = 2'b01;
        #1;
        check("t1_stall", 32'(bus.o_stall), 32'd1);
        check("t1_stall_rs1", 32'(bus.o_stall_rs1), 32'd1);
        check("t1_stall_rs2", 32'(bus.o_stall_rs2), 32'd0);
        tick();
        bus.i_rs2 = 5'd5;  bus.i_check_regs = 2'b11;
        #1;
        check("t1_both_rs1", 32'(bus.o_stall_rs1), 32'd1);
        check("t1_both_rs2", 32'(bus.o_stall_rs2), 32'd1);
        bus.i_check_regs = 2'b01;
        bus.i_wb_valid = 1'b1;  bus.i_wb_rd = 5'd5;
        #1;
        check("t1_wb_bypass", 32'(bus.o_stall), 32'd0);
        check("t1_wb_rs1", 32'(bus.o_stall_rs1), 32'd0);
        tick();
        check("t1_busy_clr", bus.o_busy_vec, 32'h0);

        // x0 is never pending; a held write does not count
        issue_wr(5'd0);
        check("t2_busy_x0", bus.o_busy_vec, 32'h0);
        idle();
        bus.i_id_valid = 1'b1;  bus.i_rs1 = 5'd0;  bus.i_rs2 = 5'd0;  bus.i_check_regs = 2'b11;
        #1;
        check("t2_stall_x0", 32'(bus.o_stall), 32'd0);
        idle();
        bus.i_id_valid = 1'b1;  bus.i_id_wr = 1'b1;  bus.i_id_rd = 5'd9;  bus.i_hold = 1'b1;
        tick();
        check("t2_hold", bus.o_busy_vec, 32'h0);

        // Issue and retire of x7 in one cycle leave pend[x7]=1
        issue_wr(5'd7);
        idle();
        bus.i_id_valid = 1'b1;  bus.i_id_wr = 1'b1;  bus.i_id_rd = 5'd7;
        bus.i_wb_valid = 1'b1;  bus.i_wb_rd = 5'd7;
        #1;
        check("t3_no_stall", 32'(bus.o_stall), 32'd0);
        tick();
        check("t3_busy7", bus.o_busy_vec, 32'h0000_0080);
        retire(5'd7);
        check("t3_one_left", bus.o_busy_vec, 32'h0);
        retire(5'd7);
        issue_wr(5'd7);
        retire(5'd7);
        check("t3_no_wrap", bus.o_busy_vec, 32'h0);

        // Saturation on x3: fourth write stalls, pend stays at 3
        issue_wr(5'd3);
        issue_wr(5'd3);
        issue_wr(5'd3);
        idle();
        bus.i_id_valid = 1'b1;  bus.i_id_wr = 1'b1;  bus.i_id_rd = 5'd3;
        #1;
        check("t4_sat_stall", 32'(bus.o_stall), 32'd1);
        check("t4_sat_rs1", 32'(bus.o_stall_rs1), 32'd0);
        tick();
        check("t4_ovf", 32'(bus.o_overflow), 32'd0);
        retire(5'd3);
        retire(5'd3);
        check("t4_pend1", bus.o_busy_vec, 32'h0000_0008);
        retire(5'd3);
        check("t4_pend0", bus.o_busy_vec, 32'h0);

        // Saturated write masked by a flush sets overflow; the drain then clears state
        issue_wr(5'd3);
        issue_wr(5'd3);
        issue_wr(5'd3);
        idle();
        bus.i_id_valid = 1'b1;  bus.i_id_wr = 1'b1;  bus.i_id_rd = 5'd3;  bus.i_flush = 1'b1;
        tick();
        check("ovf_set", 32'(bus.o_overflow), 32'd1);
        check("ovf_drain", 32'(bus.o_draining), 32'd1);
        idle();
        bus.i_pipe_empty = 1'b1;
        tick();
        check("ovf_run", 32'(bus.o_draining), 32'd0);
        check("ovf_busy", bus.o_busy_vec, 32'h0);
        check("ovf_sticky", 32'(bus.o_overflow), 32'd1);

        // Flush with pend[x4]=2; the pipe reports empty on the 4th drain cycle
        issue_wr(5'd4);
        issue_wr(5'd4);
        idle();
        bus.i_flush = 1'b1;
        #1;
        check("t5_pre_stall", 32'(bus.o_stall), 32'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            idle();
            bus.i_pipe_empty = (i == 4);
            if (i == 2) begin
                bus.i_wb_valid = 1'b1;  bus.i_wb_rd = 5'd4;
            end
            #1;
            check($sformatf("t5_drain%0d", i), 32'(bus.o_draining), 32'd1);
            check($sformatf("t5_stall%0d", i), 32'(bus.o_stall), 32'd1);
            if (i == 3) check("t5_busy_mid", bus.o_busy_vec, 32'h0000_0010);
            tick();
        end
        check("t5_run", 32'(bus.o_draining), 32'd0);
        check("t5_busy_clr", bus.o_busy_vec, 32'h0);

        // Flush and pipe-empty together: one drain cycle
        idle();
        bus.i_flush = 1'b1;  bus.i_pipe_empty = 1'b1;
        tick();
        check("both_drain", 32'(bus.o_draining), 32'd1);
        tick();
        check("both_run", 32'(bus.o_draining), 32'd0);

        // Asynchronous reset mid-drain
        idle();
        bus.i_flush = 1'b1;
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_drain", 32'(bus.o_draining), 32'd0);
        check("arst_stall", 32'(bus.o_stall), 32'd0);
        check("arst_cnt", 32'(bus.o_stall_cnt), 32'd0);
        check("arst_ovf", 32'(bus.o_overflow), 32'd0);
        #1 rst = 1'b0;

        // Stall counter saturates at 4'hF
        idle();
        bus.i_flush = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 14; i++) tick();
        check("t6_cnt14", 32'(bus.o_stall_cnt), 32'hE);
        tick();
        check("t6_cnt15", 32'(bus.o_stall_cnt), 32'hF);
        for (int i = 0; i < 5; i++) tick();
        check("t6_cnt_sat", 32'(bus.o_stall_cnt), 32'hF);
        bus.i_pipe_empty = 1'b1;
        tick();
        check("t6_run", 32'(bus.o_draining), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
